parking_ctrl_n: RTL and testbench

Parametrised parking-lot controller for N_SPOTS spots. It tracks occupancy as a bitmap and allocates the lowest-index free spot on entry. It releases a selected spot on exit and drives a timed door/blink sequence. It sits between the entry/exit button debouncers and the display/BCD layer, which consumes free_count and next_spot.

---
 rtl/parking_ctrl_n.sv | 221 ++++++++++++++++++++++
 tb/tb_parking_ctrl_n.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_n.sv
// Parking-lot controller: occupancy bitmap, lowest-free-spot allocation, timed door/blink sequence.
// Optional `PARK_STATS_EN` adds saturating entry/reject counters (entry_total, reject_total).
module parking_ctrl_n #(
  parameter  int N_SPOTS     = 4,
  parameter  int BLINK_HALF  = 2,
  parameter  int BLINK_COUNT = 3,
  localparam int SPOT_W      = (N_SPOTS > 1) ? $clog2(N_SPOTS) : 1,
  localparam int CNT_W       = $clog2(N_SPOTS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter,
  input  logic                exit,
  input  logic [SPOT_W-1:0]   exit_spot,
  output logic                door_open,
  output logic                blink_led,
  output logic                is_full,
  output logic [CNT_W-1:0]    free_count,
  output logic [SPOT_W-1:0]   next_spot,
  output logic                next_valid,
  output logic [N_SPOTS-1:0]  occupancy,
  output logic                reject,
  output logic                exit_err
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]         entry_total,
  output logic [15:0]         reject_total
`endif
);

  localparam int TOTAL  = 2 * BLINK_HALF * BLINK_COUNT;
  localparam int CYC_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TOTAL - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N_SPOTS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [N_SPOTS-1:0]  r_occ, w_occ_next;
  logic                r_door, w_door_next;
  logic                r_blink, w_blink_next;
  logic                r_reject, w_reject_next;
  logic                r_exit_err, w_exit_err_next;
  logic [CYC_W-1:0]    r_cycle, w_cycle_next;
  logic [HALF_W-1:0]   r_half, w_half_next;

  logic                w_full;
  logic [CNT_W-1:0]    w_pop;
  logic [SPOT_W-1:0]   w_next_spot;
  logic                w_found;
  logic [N_SPOTS-1:0]  w_alloc_mask;
  logic [N_SPOTS-1:0]  w_exit_mask;
  logic                w_exit_hit;
  logic                w_accept_enter;
  logic                w_reject_evt;

  // Decode exit_spot to a one-hot mask; indices >= N_SPOTS decode to zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_SPOTS; gi++) begin : g_exit_dec
      assign w_exit_mask[gi] = (exit_spot == SPOT_W'(gi));
    end
  endgenerate

  assign w_exit_hit   = |(w_exit_mask & r_occ);
  assign w_full       = &r_occ;
  // Lowest clear bit of the bitmap, isolated by the add-one carry trick.
  assign w_alloc_mask = ~r_occ & (r_occ + N_SPOTS'(1));

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      w_pop = w_pop + CNT_W'(r_occ[i]);
    end
  end

  always_comb begin
    w_next_spot = '0;
    w_found     = 1'b0;
    for (int i = 0; i < N_SPOTS; i++) begin
      if (!w_found && !r_occ[i]) begin
        w_next_spot = SPOT_W'(i);
        w_found     = 1'b1;
      end
    end
  end

  assign w_accept_enter = (r_state == S_IDLE) && enter && !exit && !w_full;
  assign w_reject_evt   = (r_state == S_IDLE) && enter && !exit && w_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_occ      <= '0;
      r_door     <= 1'b0;
      r_blink    <= 1'b0;
      r_reject   <= 1'b0;
      r_exit_err <= 1'b0;
      r_cycle    <= '0;
      r_half     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_occ      <= w_occ_next;
      r_door     <= w_door_next;
      r_blink    <= w_blink_next;
      r_reject   <= w_reject_next;
      r_exit_err <= w_exit_err_next;
      r_cycle    <= w_cycle_next;
      r_half     <= w_half_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_occ_next      = r_occ;
    w_door_next     = r_door;
    w_blink_next    = r_blink;
    w_cycle_next    = r_cycle;
    w_half_next     = r_half;
    w_reject_next   = 1'b0;
    w_exit_err_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enter && !exit) begin
          if (!w_full) begin
            w_occ_next   = r_occ | w_alloc_mask;
            w_door_next  = 1'b1;
            w_blink_next = 1'b1;
            w_cycle_next = '0;
            w_half_next  = '0;
            w_state_next = S_OPEN;
          end else begin
            w_reject_next = 1'b1;
            w_state_next  = S_HOLD;
          end
        end else if (exit && !enter) begin
          if (w_exit_hit) begin
            w_occ_next   = r_occ & ~w_exit_mask;
            w_door_next  = 1'b1;
            w_blink_next = 1'b1;
            w_cycle_next = '0;
            w_half_next  = '0;
            w_state_next = S_OPEN;
          end else begin
            w_exit_err_next = 1'b1;
            w_state_next    = S_HOLD;
          end
        end
      end

      S_OPEN: begin
        if (r_cycle == CYC_LAST) begin
          w_door_next  = 1'b0;
          w_blink_next = 1'b0;
          w_cycle_next = '0;
          w_half_next  = '0;
          w_state_next = S_HOLD;
        end else begin
          w_cycle_next = r_cycle + CYC_W'(1);
          if (r_half == HALF_LAST) begin
            w_half_next  = '0;
            w_blink_next = ~r_blink;
          end else begin
            w_half_next = r_half + HALF_W'(1);
          end
        end
      end

      // Wait for both buttons to be released so a held button yields one event.
      S_HOLD: begin
        if (!enter && !exit) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign door_open  = r_door;
  assign blink_led  = r_blink;
  assign occupancy  = r_occ;
  assign reject     = r_reject;
  assign exit_err   = r_exit_err;
  assign is_full    = w_full;
  assign next_valid = ~w_full;
  assign next_spot  = w_next_spot;
  assign free_count = N_CNT - w_pop;

`ifdef PARK_STATS_EN
  logic [15:0] r_entry_total;
  logic [15:0] r_reject_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry_total  <= '0;
      r_reject_total <= '0;
    end else begin
      if (w_accept_enter && (r_entry_total != 16'hFFFF)) begin
        r_entry_total <= r_entry_total + 16'd1;
      end
      if (w_reject_evt && (r_reject_total != 16'hFFFF)) begin
        r_reject_total <= r_reject_total + 16'd1;
      end
    end
  end

  assign entry_total  = r_entry_total;
  assign reject_total = r_reject_total;
`endif

endmodule

// File: tb/tb_parking_ctrl_n.sv
// Directed self-checking bench for parking_ctrl_n (default parameters: 4 spots, 12-cycle door).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_parking_ctrl_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic        exit;
  logic [1:0]  exit_spot;
  logic        door_open;
  logic        blink_led;
  logic        is_full;
  logic [2:0]  free_count;
  logic [1:0]  next_spot;
  logic        next_valid;
  logic [3:0]  occupancy;
  logic        reject;
  logic        exit_err;
`ifdef PARK_STATS_EN
  logic [15:0] entry_total;
  logic [15:0] reject_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parking_ctrl_n dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .exit       (exit),
    .exit_spot  (exit_spot),
    .door_open  (door_open),
    .blink_led  (blink_led),
    .is_full    (is_full),
    .free_count (free_count),
    .next_spot  (next_spot),
    .next_valid (next_valid),
    .occupancy  (occupancy),
    .reject     (reject),
    .exit_err   (exit_err)
`ifdef PARK_STATS_EN
    ,
    .entry_total  (entry_total),
    .reject_total (reject_total)
`endif
  );

  // One-cycle request followed by enough idle time for door, hold and return to idle.
  task automatic pulse_enter();
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic pulse_exit(input logic [1:0] spot);
    @(negedge clk);
    exit      = 1'b1;
    exit_spot = spot;
    @(negedge clk);
    exit = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enter = 1'b0; exit = 1'b0; exit_spot = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (occupancy !== 4'b0000) begin $display("FAIL reset_occ: got %b expected 0000", occupancy); n_fail++; end
    n_checks++;
    if (free_count !== 3'd4) begin $display("FAIL reset_free: got %0d expected 4", free_count); n_fail++; end
    n_checks++;
    if (next_spot !== 2'd0 || next_valid !== 1'b1 || is_full !== 1'b0) begin
      $display("FAIL reset_next: got spot=%0d valid=%b full=%b expected 0 1 0", next_spot, next_valid, is_full); n_fail++;
    end
    n_checks++;
    if (door_open !== 1'b0 || blink_led !== 1'b0 || reject !== 1'b0 || exit_err !== 1'b0) begin
      $display("FAIL reset_outs: got door=%b blink=%b rej=%b err=%b expected all 0", door_open, blink_led, reject, exit_err); n_fail++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_enter_door();
    logic exp_blink;
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    n_checks++;
    if (occupancy !== 4'b0001) begin $display("FAIL enter_occ: got %b expected 0001", occupancy); n_fail++; end
    n_checks++;
    if (free_count !== 3'd3 || next_spot !== 2'd1) begin
      $display("FAIL enter_counts: got free=%0d next=%0d expected 3 1", free_count, next_spot); n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      exp_blink = ((i / 2) % 2) == 0;
      n_checks++;
      if (door_open !== 1'b1 || blink_led !== exp_blink) begin
        $display("FAIL door_cycle%0d: got door=%b blink=%b expected 1 %b", i, door_open, blink_led, exp_blink); n_fail++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (door_open !== 1'b0 || blink_led !== 1'b0) begin
      $display("FAIL door_end: got door=%b blink=%b expected 0 0", door_open, blink_led); n_fail++;
    end
    repeat (3) @(negedge clk);
    $display("test_enter_door done: occ=%b", occupancy);
  endtask

  task automatic test_full_reject();
    repeat (3) pulse_enter();
    n_checks++;
    if (occupancy !== 4'b1111 || is_full !== 1'b1 || next_valid !== 1'b0 || free_count !== 3'd0 || next_spot !== 2'd0) begin
      $display("FAIL full_state: got occ=%b full=%b valid=%b free=%0d next=%0d expected 1111 1 0 0 0",
               occupancy, is_full, next_valid, free_count, next_spot); n_fail++;
    end
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    n_checks++;
    if (reject !== 1'b1 || door_open !== 1'b0) begin
      $display("FAIL reject_pulse: got rej=%b door=%b expected 1 0", reject, door_open); n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (reject !== 1'b0 || door_open !== 1'b0) begin
      $display("FAIL reject_width: got rej=%b door=%b expected 0 0", reject, door_open); n_fail++;
    end
    enter = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (occupancy !== 4'b1111) begin $display("FAIL reject_occ: got %b expected 1111", occupancy); n_fail++; end
    $display("test_full_reject done");
  endtask

  task automatic test_exit_refill();
    @(negedge clk);
    exit = 1'b1; exit_spot = 2'd2;
    @(negedge clk);
    exit = 1'b0;
    n_checks++;
    if (occupancy !== 4'b1011 || next_spot !== 2'd2 || free_count !== 3'd1 || door_open !== 1'b1) begin
      $display("FAIL exit_spot2: got occ=%b next=%0d free=%0d door=%b expected 1011 2 1 1",
               occupancy, next_spot, free_count, door_open); n_fail++;
    end
    repeat (16) @(negedge clk);
    pulse_enter();
    n_checks++;
    if (occupancy !== 4'b1111) begin $display("FAIL refill: got %b expected 1111", occupancy); n_fail++; end
    $display("test_exit_refill done");
  endtask

  task automatic test_exit_err();
    int extra;
    pulse_exit(2'd1);
    n_checks++;
    if (occupancy !== 4'b1101) begin $display("FAIL exit_spot1: got %b expected 1101", occupancy); n_fail++; end
    @(negedge clk);
    exit = 1'b1; exit_spot = 2'd1;
    @(negedge clk);
    n_checks++;
    if (exit_err !== 1'b1 || door_open !== 1'b0) begin
      $display("FAIL exit_err_pulse: got err=%b door=%b expected 1 0", exit_err, door_open); n_fail++;
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (exit_err === 1'b1 || door_open === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin $display("FAIL exit_err_held: got %0d extra events expected 0", extra); n_fail++; end
    exit = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (occupancy !== 4'b1101) begin $display("FAIL exit_err_occ: got %b expected 1101", occupancy); n_fail++; end
    $display("test_exit_err done");
  endtask

  task automatic test_both_and_held();
    int events;
    int doors;
    logic prev_door;
    @(negedge clk);
    enter = 1'b1; exit = 1'b1; exit_spot = 2'd0;
    events = 0;
    repeat (4) begin
      @(negedge clk);
      if (reject === 1'b1 || exit_err === 1'b1 || door_open === 1'b1) events++;
    end
    enter = 1'b0; exit = 1'b0;
    n_checks++;
    if (events !== 0 || occupancy !== 4'b1101) begin
      $display("FAIL both_pressed: got events=%0d occ=%b expected 0 1101", events, occupancy); n_fail++;
    end
    @(negedge clk);
    enter = 1'b1;
    doors = 0; events = 0; prev_door = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (door_open === 1'b1 && prev_door === 1'b0) doors++;
      if (reject === 1'b1) events++;
      prev_door = door_open;
    end
    enter = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (doors !== 1 || events !== 0 || occupancy !== 4'b1111) begin
      $display("FAIL enter_held: got doors=%0d rejects=%0d occ=%b expected 1 0 1111", doors, events, occupancy); n_fail++;
    end
    $display("test_both_and_held done");
  endtask

  task automatic test_reset_mid_open();
    pulse_exit(2'd3);
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (door_open !== 1'b1 || occupancy !== 4'b1111) begin
      $display("FAIL pre_abort: got door=%b occ=%b expected 1 1111", door_open, occupancy); n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (door_open !== 1'b0 || blink_led !== 1'b0 || occupancy !== 4'b0000 || free_count !== 3'd4) begin
      $display("FAIL abort: got door=%b blink=%b occ=%b free=%0d expected 0 0 0000 4",
               door_open, blink_led, occupancy, free_count); n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset_mid_open done");
  endtask

`ifdef PARK_STATS_EN
  task automatic test_stats();
    repeat (4) pulse_enter();
    @(negedge clk);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (entry_total !== 16'd4 || reject_total !== 16'd1) begin
      $display("FAIL stats_count: got entry=%0d reject=%0d expected 4 1", entry_total, reject_total); n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (entry_total !== 16'd0 || reject_total !== 16'd0) begin
      $display("FAIL stats_reset: got entry=%0d reject=%0d expected 0 0", entry_total, reject_total); n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    $display("test_stats done");
  endtask
`endif

  initial begin
    test_reset();
    test_enter_door();
    test_full_reject();
    test_exit_refill();
    test_exit_err();
    test_both_and_held();
    test_reset_mid_open();
`ifdef PARK_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
